multi_chan_hs_fsm: RTL and testbench



---
 rtl/hs_fsm_pkg.sv | 22 ++
 rtl/hs_chan_fsm.sv | 98 +++++++++
 rtl/multi_chan_hs_fsm.sv | 43 ++++
 tb/tb_multi_chan_hs_fsm.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_fsm_pkg.sv
// Shared types and helpers for the multi-channel done/ack sequencer.
// Optional timeout/error path is enabled by HS_TIMEOUT_EN.
package hs_fsm_pkg;

  localparam int HS_STATE_W = 3;

  typedef enum logic [HS_STATE_W-1:0] {
    READY = 3'd0,
    TRANS = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    ERR   = 3'd4
  } hs_state_t;

  function automatic logic is_active(
    input logic [HS_STATE_W-1:0] s
  );
    return (s == TRANS) || (s == WRITE) ||
           (s == READ);
  endfunction

endpackage

// File: rtl/hs_chan_fsm.sv
// One handshake channel: state, ack pulse, txn counter, timeout.
// Timer and ERR state exist only when HS_TIMEOUT_EN is defined.
module hs_chan_fsm
  import hs_fsm_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TO_W        = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_done,
  input  logic                  i_clr_err,
  output logic                  o_ack,
  output logic [HS_STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]      o_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  logic [HS_STATE_W-1:0] r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ack;
  logic [HS_STATE_W-1:0] w_leg;
  logic [HS_STATE_W-1:0] w_nxt;
  logic                  w_inc;

  always_comb begin
    w_leg = r_state;
    w_inc = 1'b0;
    case (r_state)
      READY: if (i_done) w_leg = TRANS;
      TRANS: if (!i_done) w_leg = WRITE;
      WRITE: if (i_done) w_leg = READ;
      READ: begin
        if (i_done) begin
          w_leg = READY;
          w_inc = 1'b1;
        end
      end
`ifdef HS_TIMEOUT_EN
      ERR: if (i_clr_err) w_leg = READY;
`endif
      default: w_leg = READY;
    endcase
  end

`ifdef HS_TIMEOUT_EN
  logic [TO_W-1:0] r_timer;
  logic            w_hold;
  logic            w_expire;

  assign w_hold   = is_active(r_state) &&
                    (w_leg == r_state);
  assign w_expire = w_hold &&
    (r_timer == TO_W'(TIMEOUT_CYC - 1));
  assign w_nxt    = w_expire ? ERR : w_leg;
  assign o_err    = (r_state == ERR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_timer <= '0;
    else if (w_hold && !w_expire)
      r_timer <= r_timer + TO_W'(1);
    else
      r_timer <= '0;
  end
`else
  logic unused_clr;
  localparam int unused_to_cfg =
    TO_W + TIMEOUT_CYC;

  assign unused_clr = i_clr_err;
  assign w_nxt      = w_leg;
  assign o_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= READY;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_ack   <= i_done &&
                 ((r_state == READY) ||
                  (r_state == WRITE));
      if (w_inc)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_ack   = r_ack;
  assign o_state = r_state;
  assign o_cnt   = r_cnt;
  assign o_busy  = is_active(r_state);

endmodule

// File: rtl/multi_chan_hs_fsm.sv
// NCH independent done/ack sequencers with packed status export.
// Define HS_TIMEOUT_EN to enable per-channel timeout and ERR state.
module multi_chan_hs_fsm
  import hs_fsm_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int TO_W        = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCH-1:0]            done,
  input  logic [NCH-1:0]            clr_err,
  output logic [NCH-1:0]            ack,
  output logic [NCH-1:0]            busy,
  output logic [NCH-1:0]            err,
  output logic [HS_STATE_W*NCH-1:0] state_o,
  output logic [CNT_W*NCH-1:0]      txn_cnt,
  output logic                      any_busy
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    hs_chan_fsm #(
      .CNT_W      (CNT_W),
      .TO_W       (TO_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .i_done   (done[c]),
      .i_clr_err(clr_err[c]),
      .o_ack    (ack[c]),
      .o_state  (state_o[HS_STATE_W*c +: HS_STATE_W]),
      .o_cnt    (txn_cnt[CNT_W*c +: CNT_W]),
      .o_busy   (busy[c]),
      .o_err    (err[c])
    );
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_multi_chan_hs_fsm.sv
// Self-checking bench for multi_chan_hs_fsm against a phase-table model.
// Timeout scenarios run only when HS_TIMEOUT_EN is defined.
module tb_multi_chan_hs_fsm;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int TO_W  = 8;
  localparam int TOC   = 5;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NCH-1:0]       done = '0;
  logic [NCH-1:0]       clr_err = '0;
  logic [NCH-1:0]       ack;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       err;
  logic [3*NCH-1:0]     state_o;
  logic [CNT_W*NCH-1:0] txn_cnt;
  logic                 any_busy;

  int checks = 0;
  int failures = 0;

  // phase 0..3 = handshake position, 4 = error
  int m_ph[NCH];
  int m_cnt[NCH];
  int m_stay[NCH];
  bit m_ack[NCH];
  int need[4] = '{1, 0, 1, 1};

  multi_chan_hs_fsm #(
    .NCH(NCH), .CNT_W(CNT_W),
    .TO_W(TO_W), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rstn(rstn), .done(done),
    .clr_err(clr_err), .ack(ack), .busy(busy),
    .err(err), .state_o(state_o),
    .txn_cnt(txn_cnt), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = 0; m_cnt[c] = 0;
      m_stay[c] = 0; m_ack[c] = 0;
    end
  endtask

  task automatic model_step(
    input logic [NCH-1:0] d,
    input logic [NCH-1:0] cl
  );
    int p, n;
    for (int c = 0; c < NCH; c++) begin
      p = m_ph[c];
      n = p;
      m_ack[c] = d[c] && (p == 0 || p == 2);
      if (p == 4) begin
        if (cl[c]) n = 0;
      end else if (int'(d[c]) == need[p]) begin
        n = (p + 1) % 4;
        if (p == 3)
          m_cnt[c] = (m_cnt[c] + 1) % 256;
      end
`ifdef HS_TIMEOUT_EN
      if (p >= 1 && p <= 3 && n == p) begin
        if (m_stay[c] == TOC - 1) n = 4;
      end
`endif
      m_stay[c] = (n == p) ? m_stay[c] + 1 : 0;
      m_ph[c] = n;
    end
  endtask

  function automatic logic [3*NCH-1:0] e_state();
    logic [3*NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[3*c +: 3] = 3'(m_ph[c]);
    return v;
  endfunction

  function automatic logic [CNT_W*NCH-1:0] e_cnt();
    logic [CNT_W*NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[CNT_W*c +: CNT_W] = CNT_W'(m_cnt[c]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] e_ack();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_ack[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] e_busy();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[c] = (m_ph[c] >= 1 && m_ph[c] <= 3);
    return v;
  endfunction

  function automatic logic [NCH-1:0] e_err();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_ph[c] == 4);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(done, clr_err);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    done = '0; clr_err = '0;
    rstn = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state_o, ack, busy, err, any_busy} !== '0 ||
        txn_cnt !== '0) begin
      failures++;
      $display("FAIL reset_outputs: state=%h ack=%b cnt=%h",
               state_o, ack, txn_cnt);
    end
  endtask

  task automatic test_full_cycle();
    int st_exp[4] = '{1, 2, 3, 0};
    bit ak_exp[4] = '{1, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      done = '0;
      done[0] = 1'(need[i]);
      tick();
      checks++;
      if (state_o[2:0] !== 3'(st_exp[i]) ||
          ack[0] !== ak_exp[i]) begin
        failures++;
        $display("FAIL full_cycle_%0d: st=%0d ack=%b want %0d/%b",
                 i, state_o[2:0], ack[0], st_exp[i], ak_exp[i]);
      end
    end
    done = '0;
    checks++;
    if (txn_cnt !== {{(CNT_W*(NCH-1)){1'b0}}, 8'd1} ||
        state_o[3*NCH-1:3] !== '0) begin
      failures++;
      $display("FAIL full_cycle_cnt: cnt=%h st=%h want cnt=1",
               txn_cnt, state_o);
    end
  endtask

  task automatic test_hold_done();
    int acks = 0;
    do_reset();
    done[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      acks += int'(ack[1]);
      checks++;
      if (state_o !== e_state() || busy !== e_busy() ||
          any_busy !== (|e_busy())) begin
        failures++;
        $display("FAIL hold_state_%0d: st=%h busy=%b want %h/%b",
                 i, state_o, busy, e_state(), e_busy());
      end
    end
    done = '0;
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL hold_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_wrap();
    int acks = 0;
    do_reset();
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < 4; i++) begin
        done[2] = 1'(need[i]);
        tick();
        acks += int'(ack[2]);
      end
      if (t == 254) begin
        checks++;
        if (txn_cnt[2*CNT_W +: CNT_W] !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255: got %0d want 255",
                   txn_cnt[2*CNT_W +: CNT_W]);
        end
      end
    end
    done = '0;
    checks++;
    if (txn_cnt[2*CNT_W +: CNT_W] !== 8'd0 || acks != 512) begin
      failures++;
      $display("FAIL wrap_end: cnt=%0d acks=%0d want 0/512",
               txn_cnt[2*CNT_W +: CNT_W], acks);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      done = NCH'($urandom);
      clr_err = ($urandom_range(0, 7) == 0) ?
                NCH'($urandom) : '0;
      tick();
      checks++;
      if (state_o !== e_state() || ack !== e_ack() ||
          txn_cnt !== e_cnt() || busy !== e_busy() ||
          err !== e_err() || any_busy !== (|e_busy())) begin
        failures++;
        $display("FAIL random_%0d: st=%h ack=%b cnt=%h err=%b want %h/%b/%h/%b",
                 i, state_o, ack, txn_cnt, err,
                 e_state(), e_ack(), e_cnt(), e_err());
      end
    end
    done = '0; clr_err = '0;
  endtask

`ifdef HS_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    done[3] = 1'b1; tick();
    done[3] = 1'b0; tick();
    for (int i = 1; i <= TOC; i++) begin
      tick();
      checks++;
      if (err[3] !== (i == TOC) ||
          state_o[11:9] !== ((i == TOC) ? 3'd4 : 3'd2)) begin
        failures++;
        $display("FAIL timeout_%0d: err=%b st=%0d", i,
                 err[3], state_o[11:9]);
      end
    end
    clr_err[3] = 1'b1; tick();
    clr_err[3] = 1'b0;
    checks++;
    if (state_o[11:9] !== 3'd0 || err[3] !== 1'b0 ||
        txn_cnt[3*CNT_W +: CNT_W] !== 8'd0) begin
      failures++;
      $display("FAIL timeout_clr: st=%0d err=%b cnt=%0d want 0/0/0",
               state_o[11:9], err[3], txn_cnt[3*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    done[3] = 1'b1; tick();
    done[3] = 1'b0; tick();
    for (int i = 0; i < TOC - 1; i++) tick();
    done[3] = 1'b1; tick();
    done[3] = 1'b0;
    checks++;
    if (state_o[11:9] !== 3'd3 || err[3] !== 1'b0 ||
        ack[3] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_race: st=%0d err=%b ack=%b want 3/0/1",
               state_o[11:9], err[3], ack[3]);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    done = '1; tick();
    done = '0; tick();
    checks++;
    if (state_o !== {NCH{3'd2}}) begin
      failures++;
      $display("FAIL areset_pre: st=%h want all WRITE", state_o);
    end
    done = '1; #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({state_o, ack, busy, err, any_busy} !== '0 ||
        txn_cnt !== '0) begin
      failures++;
      $display("FAIL areset_now: st=%h ack=%b busy=%b cnt=%h",
               state_o, ack, busy, txn_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== '0 || ack !== '0) begin
      failures++;
      $display("FAIL areset_hold: st=%h ack=%b", state_o, ack);
    end
    done = '0;
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_hold_done();
    test_wrap();
    test_random();
`ifdef HS_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
